uart_tx_fifo: RTL and testbench

- Byte buffer and dispatcher directly upstream of uart_tx.
- Accepts bytes from a producer (command/echo logic, string generator) at clock rate, stores them in a circular FIFO, and hands them one at a time to uart_tx.
- Each handoff is a single-cycle tx_valid pulse; the block then waits for the transmitter's done/active handshake before issuing the next byte.
- A watchdog recovers the dispatcher if the transmitter never completes.

---
 rtl/uart_pkg.sv | 18 +
 rtl/sync_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: dispatcher state encodings, data width and FIFO count sizing.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StWaitActive = 2'd1,
        StWaitDone   = 2'd2,
        StWaitIdle   = 2'd3
    } tx_state_e;

    // Occupancy must represent 0..depth inclusive, hence one bit more than the pointer.
    function automatic int unsigned count_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered occupancy, combinational full/empty and a sticky overflow flag.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = UART_DATA_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_wr_en,
    input  logic [WIDTH-1:0]          i_wr_data,
    input  logic                      i_rd_en,
    output logic [WIDTH-1:0]          o_rd_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = count_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             w_wr;
    logic             w_rd;

    // Full is judged on the pre-edge count, so a concurrent read never rescues a write.
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_wr       = i_wr_en & ~o_full;
    assign w_rd       = i_rd_en & ~o_empty;
    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_count <= r_count - 1'b1;
            end
            if (i_wr_en && o_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer feeding uart_tx: FIFO plus a one-byte-at-a-time dispatcher guarded by a watchdog.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TIMEOUT_CLKS = 2_000_000
) (
    input  logic                      source_clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [UART_DATA_W-1:0]    wr_data,
    output logic                      full,
    output logic                      empty,
    output logic [count_w(DEPTH)-1:0] count,
    output logic                      overflow,
    output logic                      tx_valid,
    output logic [UART_DATA_W-1:0]    tx_message,
    input  logic                      tx_active,
    input  logic                      tx_done,
    output logic                      timeout
);

    localparam int unsigned     WDW     = $clog2(TIMEOUT_CLKS);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CLKS - 1);

    tx_state_e              r_state;
    tx_state_e              w_state_d;
    logic [WDW-1:0]         r_wd;
    logic [WDW-1:0]         w_wd_d;
    logic                   r_tx_valid;
    logic                   w_tx_valid_d;
    logic [UART_DATA_W-1:0] r_tx_message;
    logic [UART_DATA_W-1:0] w_tx_message_d;
    logic                   r_timeout;
    logic                   w_timeout_d;
    logic                   w_dispatch;
    logic [UART_DATA_W-1:0] w_fifo_data;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .i_clk      (source_clk),
        .i_rst      (rst),
        .i_wr_en    (wr_en),
        .i_wr_data  (wr_data),
        .i_rd_en    (w_dispatch),
        .o_rd_data  (w_fifo_data),
        .o_full     (full),
        .o_empty    (empty),
        .o_count    (count),
        .o_overflow (overflow)
    );

    always_comb begin
        w_state_d      = r_state;
        w_wd_d         = r_wd;
        w_tx_valid_d   = 1'b0;
        w_tx_message_d = r_tx_message;
        w_timeout_d    = r_timeout;
        w_dispatch     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!empty && !tx_active) begin
                    w_dispatch     = 1'b1;
                    w_tx_valid_d   = 1'b1;
                    w_tx_message_d = w_fifo_data;
                    w_wd_d         = '0;
                    w_state_d      = StWaitActive;
                end
            end
            StWaitActive: begin
                // A transmitter may finish without ever showing active; accept done directly.
                if (tx_done) begin
                    w_state_d = StWaitIdle;
                end else if (tx_active) begin
                    w_state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_done) begin
                    w_state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (!tx_active) begin
                    w_state_d = StIdle;
                end
            end
        endcase

        // Watchdog overrides the handshake: the stuck byte is abandoned, not retried.
        if (r_state == StWaitActive || r_state == StWaitDone) begin
            if (r_wd == WD_LAST) begin
                w_timeout_d = 1'b1;
                w_state_d   = StIdle;
            end else begin
                w_wd_d = r_wd + 1'b1;
            end
        end
    end

    always_ff @(posedge source_clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_wd         <= '0;
            r_tx_valid   <= 1'b0;
            r_tx_message <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_wd         <= w_wd_d;
            r_tx_valid   <= w_tx_valid_d;
            r_tx_message <= w_tx_message_d;
            r_timeout    <= w_timeout_d;
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_message = r_tx_message;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue scoreboard, uart_tx frame model, vector table and corner sequences.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 50;
    localparam int          FRAME   = 40;
    localparam int          HANG    = 70;

    logic       source_clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_valid;
    logic [7:0] tx_message;
    logic       tx_active;
    logic       tx_done;
    logic       timeout;

    uart_tx_fifo #(
        .DEPTH        (DEPTH),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .source_clk (source_clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_valid   (tx_valid),
        .tx_message (tx_message),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .timeout    (timeout)
    );

    always #5 source_clk = ~source_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int vld_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge source_clk) cyc <= cyc + 1;

    // uart_tx stand-in: frame of FRAME clocks after tx_valid, or HANG clocks with no done.
    logic m_active;
    logic m_done;
    int   m_cnt;
    bit   hang;
    bit   hang_cap;
    bit   hold_active;

    assign tx_active = m_active | hold_active;
    assign tx_done   = m_done;

    always @(posedge source_clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            hang_cap <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_active <= 1'b0;
                    m_done   <= !hang_cap;
                end
            end else if (tx_valid) begin
                m_active <= 1'b1;
                m_cnt    <= hang ? HANG : FRAME;
                hang_cap <= hang;
            end
        end
    end

    // Reference: bytes accepted but not yet dispatched, in order.
    logic [7:0] q[$];
    logic       exp_ovf;

    always @(posedge source_clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_ovf <= 1'b0;
        end else if (wr_en) begin
            if (q.size() == DEPTH) exp_ovf <= 1'b1;
            else q.push_back(wr_data);
        end
    end

    logic       prev_vld;
    logic [7:0] occ_exp;

    always @(negedge source_clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (tx_valid) begin
                vld_cnt++;
                chk("tx_valid_back_to_back", prev_vld, 1'b0);
                chk("tx_valid_while_active", tx_active, 1'b0);
                chk("dispatch_has_data", q.size() != 0, 1'b1);
                if (q.size() != 0) begin
                    chk("tx_message_order", tx_message, q[0]);
                    q.pop_front();
                end
            end
            prev_vld = tx_valid;
            occ_exp = {5'(q.size()), q.size() == DEPTH, q.size() == 0, exp_ovf};
            chk("occupancy_flags", {count, full, empty, overflow}, occ_exp);
        end
    end

    task automatic tick();
        @(posedge source_clk);
        #2;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        hold_active = 1'b0;
        hang        = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(q.size() == 0 && empty && !tx_active && !tx_valid) && n < bound) begin
            tick();
            n++;
        end
        chk("drain_within_bound", n < bound, 1'b1);
        repeat (4) tick();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] data;
        int         cnt;
        logic       full;
        logic       ovf;
    } vec_t;

    vec_t tbl[20];
    int   v0;
    int   d;
    int   n;

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(i * 7 + 3), i + 1, i == 15, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 16, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 8'hFF, 16, 1'b1, 1'b1};
        tbl[18] = '{1'b1, 8'hFE, 16, 1'b1, 1'b1};
        tbl[19] = '{1'b0, 8'h00, 16, 1'b1, 1'b1};

        // Single byte: reset state, latency and pulse width.
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_message", tx_message, 8'h00);
        chk("rst_timeout", timeout, 1'b0);
        v0 = vld_cnt;
        wr_en = 1'b1; wr_data = 8'h41;
        tick();
        wr_en = 1'b0;
        chk("t1_count_after_write", count, 1);
        chk("t1_no_valid_yet", tx_valid, 1'b0);
        tick();
        chk("t1_valid_pulse", tx_valid, 1'b1);
        chk("t1_message", tx_message, 8'h41);
        chk("t1_count_zero", count, 0);
        tick();
        chk("t1_valid_one_cycle", tx_valid, 1'b0);
        chk("t1_message_held", tx_message, 8'h41);
        wait_idle(300);
        chk("t1_single_dispatch", vld_cnt - v0, 1);
        chk("t1_no_timeout", timeout, 1'b0);

        // Vector table with the transmitter held busy: fill, then writes while full.
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en = tbl[i].wr; wr_data = tbl[i].data;
            tick();
            chk("tbl_count", count, tbl[i].cnt);
            chk("tbl_full", full, tbl[i].full);
            chk("tbl_empty", empty, tbl[i].cnt == 0);
            chk("tbl_overflow", overflow, tbl[i].ovf);
        end
        wr_en = 1'b0;
        v0 = vld_cnt;
        hold_active = 1'b0;
        wait_idle(2000);
        chk("tbl_frames_sent", vld_cnt - v0, 16);
        chk("tbl_overflow_sticky", overflow, 1'b1);

        // Write while full in the same cycle as a dispatch read.
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            tick();
        end
        hold_active = 1'b0;
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        chk("t4_count", count, 15);
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_dispatch", tx_valid, 1'b1);
        chk("t4_message", tx_message, 8'h80);
        wait_idle(2000);

        // Burst 00..0F buffered, then drained in order.
        do_reset();
        hold_active = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("t2_full", full, 1'b1);
        chk("t2_no_overflow", overflow, 1'b0);
        v0 = vld_cnt;
        hold_active = 1'b0;
        wait_idle(2000);
        chk("t2_frames_sent", vld_cnt - v0, 16);

        // Random writes against the queue model, heavy then light traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            wr_en   = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
            wr_data = 8'($urandom);
            tick();
        end
        wr_en = 1'b0;
        wait_idle(3000);
        chk("rand_no_timeout", timeout, 1'b0);

        // Watchdog: first byte never completes, second follows once active drops.
        do_reset();
        hang = 1'b1;
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_data = 8'hB5;
        tick();
        wr_en = 1'b0;
        chk("t5_first_dispatch", tx_valid, 1'b1);
        d = cyc;
        tick();
        hang = 1'b0;
        while (cyc < d + TIMEOUT - 1) tick();
        chk("t5_timeout_not_early", timeout, 1'b0);
        tick();
        chk("t5_timeout_set", timeout, 1'b1);
        n = 0;
        while (!tx_valid && n < 200) begin
            tick();
            n++;
        end
        chk("t5_redispatch_seen", n < 200, 1'b1);
        chk("t5_redispatch_cycle", cyc - d, 72);
        chk("t5_redispatch_byte", tx_message, 8'hB5);
        wait_idle(300);
        chk("t5_timeout_sticky", timeout, 1'b1);

        // Asynchronous reset mid-burst with five bytes buffered.
        hold_active = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t6_count_before", count, 5);
        @(negedge source_clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", count, 0);
        chk("t6_async_empty", empty, 1'b1);
        chk("t6_async_timeout", timeout, 1'b0);
        chk("t6_async_tx_valid", tx_valid, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        hold_active = 1'b0;
        v0 = vld_cnt;
        repeat (30) tick();
        chk("t6_no_dispatch_after_reset", vld_cnt - v0, 0);
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        wait_idle(300);
        chk("t6_new_byte_dispatched", vld_cnt - v0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

endmodule
